// File: rtl/display_planes.sv
// Bitplane framebuffer scanout with palette, scaling and prefetch.
// Planes combine into a palette index and drive RGB332 to the VGA stage.
module display_planes #(
  parameter int PLANES         = 2,
  parameter int WORD_W         = 16,
  parameter int ADDR_W         = 10,
  parameter int PLANE_WORDS    = 512,
  parameter int H_MULT_LO      = 10,
  parameter int H_MULT_HI      = 5,
  parameter int V_MULT_WIDE_LO = 12,
  parameter int V_MULT_WIDE_HI = 6
) (
  input  logic              clk,
  input  logic              res_n,
  input  logic              hires,
  input  logic              wide,
  input  logic              enable_pixel,
  input  logic [10:0]       h_pixel,
  input  logic [10:0]       v_pixel,
  input  logic              hsync,
  input  logic              vsync,
  input  logic              pal_we,
  input  logic [PLANES-1:0] pal_idx,
  input  logic [7:0]        pal_data,
  output logic [ADDR_W-1:0] fb_addr,
  input  logic [WORD_W-1:0] fb_data,
  output logic [7:0]        rgb,
  output logic              outside_playfield,
  output logic              underrun
);

  localparam int NPAL = 1 << PLANES;
  localparam int BW   = $clog2(WORD_W);
  localparam int PW   = (PLANES > 1) ? $clog2(PLANES) : 1;
  localparam logic [7:0] WPL_LO = 8'(64 / WORD_W);
  localparam logic [7:0] WPL_HI = 8'(128 / WORD_W);
  localparam logic [PW-1:0] PLAST = PW'(PLANES - 1);

  typedef enum logic [1:0] {
    S_IDLE, S_ISSUE, S_CAPTURE, S_READY
  } state_t;

  function automatic logic [7:0] pal_init(int i);
    case (i)
      1:       return 8'hFF;
      2:       return 8'hD9;
      3:       return 8'h6D;
      default: return 8'h00;
    endcase
  endfunction

  state_t              r_state;
  state_t              w_next;
  logic [PW-1:0]       r_plane;
  logic [PW-1:0]       w_plane_nx;
  logic [ADDR_W-1:0]   r_fb_addr;
  logic [ADDR_W-1:0]   w_addr_nx;
  logic [ADDR_W-1:0]   r_base;
  logic [ADDR_W-1:0]   w_base_now;
  logic                w_cap;
  logic [PW-1:0]       w_cap_plane;
  logic                w_set_valid;
  logic                w_take;

  logic [WORD_W-1:0]   r_hold [PLANES];
  logic [WORD_W-1:0]   r_sh   [PLANES];
  logic                r_hold_valid;
  logic                r_req;
  logic                r_underrun;
  logic [7:0]          r_pal  [NPAL];
  logic [7:0]          r_rgb;

  logic [ADDR_W-1:0]   r_line_addr;
  logic [ADDR_W-1:0]   r_cur_line;
  logic [7:0]          r_word_idx;
  logic [3:0]          r_vcnt;
  logic [3:0]          r_hsub;
  logic [BW-1:0]       r_bit;

  logic [3:0]          w_hm;
  logic [3:0]          w_vm;
  logic [7:0]          w_wpl;
  logic                w_inside;
  logic                w_hsync_go;
  logic                w_load_pt;
  logic                w_strobe;
  logic                w_last_sub;
  logic                w_bound;
  logic                w_load;
  logic                w_req_new;
  logic                w_border;
  logic [PLANES-1:0]   w_idx;

  assign w_hm  = hires ? 4'(H_MULT_HI) : 4'(H_MULT_LO);
  assign w_vm  = wide ? (hires ? 4'(V_MULT_WIDE_HI)
                               : 4'(V_MULT_WIDE_LO))
                      : w_hm;
  assign w_wpl = hires ? WPL_HI : WPL_LO;

  assign w_inside = wide
    ? (v_pixel >= 11'd48 && v_pixel <= 11'd431)
    : (v_pixel >= 11'd80 && v_pixel <= 11'd399);
  assign outside_playfield = !w_inside;

  assign w_hsync_go = hsync && w_inside && !vsync;
  assign w_load_pt  = w_inside && !vsync &&
                      h_pixel == 11'h7FC &&
                      r_word_idx == 8'd0;
  assign w_strobe   = enable_pixel && w_inside && !vsync;
  assign w_last_sub = r_hsub == 4'(w_hm - 4'd1);
  assign w_bound    = w_strobe && w_last_sub &&
                      r_bit == BW'(WORD_W - 1) &&
                      r_word_idx < w_wpl;
  assign w_load     = w_load_pt || w_bound;
  assign w_req_new  = w_hsync_go ||
                      (w_load && (r_word_idx + 8'd1) < w_wpl);
  assign w_border   = v_pixel == 11'd0 || v_pixel == 11'd479;
  assign w_base_now = r_cur_line + ADDR_W'(r_word_idx);

  assign fb_addr  = r_fb_addr;
  assign rgb      = r_rgb;
  assign underrun = r_underrun;

  // Current pixel's palette index from the shifter MSBs.
  always_comb begin
    w_idx = '0;
    for (int p = 0; p < PLANES; p++) w_idx[p] = r_sh[p][WORD_W-1];
  end

  // Fetch FSM next state: one issue per plane, then capture, then ready.
  always_comb begin
    w_next      = r_state;
    w_plane_nx  = r_plane;
    w_addr_nx   = r_fb_addr;
    w_cap       = 1'b0;
    w_cap_plane = '0;
    w_set_valid = 1'b0;
    w_take      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (r_req) begin
          w_next     = S_ISSUE;
          w_plane_nx = '0;
          w_addr_nx  = w_base_now;
          w_take     = 1'b1;
        end
      end
      S_ISSUE: begin
        if (r_plane != '0) begin
          w_cap       = 1'b1;
          w_cap_plane = r_plane - PW'(1);
        end
        if (r_plane == PLAST) begin
          w_next = S_CAPTURE;
        end else begin
          w_plane_nx = r_plane + PW'(1);
          w_addr_nx  = r_base + ADDR_W'(PLANE_WORDS) *
                       ADDR_W'(r_plane + PW'(1));
        end
      end
      S_CAPTURE: begin
        w_cap       = 1'b1;
        w_cap_plane = PLAST;
        w_next      = S_READY;
      end
      S_READY: begin
        w_set_valid = 1'b1;
        w_next      = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Fetch FSM state, plane counter and address register.
  always_ff @(posedge clk) begin
    if (!res_n) begin
      r_state   <= S_IDLE;
      r_plane   <= '0;
      r_fb_addr <= '0;
      r_base    <= '0;
    end else begin
      r_state   <= w_next;
      r_plane   <= w_plane_nx;
      r_fb_addr <= w_addr_nx;
      if (w_take) r_base <= w_base_now;
    end
  end

  // Hold buffers, request/valid flags, shifters and underrun.
  always_ff @(posedge clk) begin
    if (!res_n) begin
      r_hold_valid <= 1'b0;
      r_req        <= 1'b0;
      r_underrun   <= 1'b0;
      for (int p = 0; p < PLANES; p++) begin
        r_hold[p] <= '0;
        r_sh[p]   <= '0;
      end
    end else begin
      if (w_cap) r_hold[w_cap_plane] <= fb_data;
      if (w_take) r_req <= 1'b0;
      if (w_req_new) r_req <= 1'b1;
      if (w_load) r_hold_valid <= 1'b0;
      if (w_set_valid) r_hold_valid <= 1'b1;
      if (w_load && !r_hold_valid) r_underrun <= 1'b1;
      for (int p = 0; p < PLANES; p++) begin
        if (w_load)
          r_sh[p] <= r_hold_valid ? r_hold[p] : '0;
        else if (w_strobe && w_last_sub)
          r_sh[p] <= r_sh[p] << 1;
      end
    end
  end

  // Horizontal sub-pixel and bit counters.
  always_ff @(posedge clk) begin
    if (!res_n) begin
      r_hsub <= '0;
      r_bit  <= '0;
    end else if (vsync || w_hsync_go || w_load_pt) begin
      r_hsub <= '0;
      r_bit  <= '0;
    end else if (w_strobe) begin
      if (w_last_sub) begin
        r_hsub <= '0;
        if (r_bit == BW'(WORD_W - 1)) r_bit <= '0;
        else r_bit <= r_bit + BW'(1);
      end else begin
        r_hsub <= r_hsub + 4'd1;
      end
    end
  end

  // Line base, vertical repeat counter and word index.
  always_ff @(posedge clk) begin
    if (!res_n) begin
      r_line_addr <= '0;
      r_cur_line  <= '0;
      r_word_idx  <= '0;
      r_vcnt      <= '0;
    end else if (vsync) begin
      r_line_addr <= '0;
      r_word_idx  <= '0;
      r_vcnt      <= 4'(w_vm - 4'd1);
    end else if (w_hsync_go) begin
      r_word_idx <= '0;
      r_cur_line <= r_line_addr;
      if (r_vcnt == 4'd0) begin
        r_vcnt      <= 4'(w_vm - 4'd1);
        r_line_addr <= r_line_addr + ADDR_W'(w_wpl);
      end else begin
        r_vcnt <= r_vcnt - 4'd1;
      end
    end else if (w_load) begin
      r_word_idx <= r_word_idx + 8'd1;
    end
  end

  // Palette storage; writes land at the edge so same-cycle reads see old data.
  always_ff @(posedge clk) begin
    if (!res_n) begin
      for (int i = 0; i < NPAL; i++) r_pal[i] <= pal_init(i);
    end else if (pal_we) begin
      r_pal[pal_idx] <= pal_data;
    end
  end

  // Registered pixel output: border lines, playfield pixels, else black.
  always_ff @(posedge clk) begin
    if (!res_n) r_rgb <= 8'h00;
    else if (enable_pixel && w_border) r_rgb <= 8'hFF;
    else if (w_inside && enable_pixel) r_rgb <= r_pal[w_idx];
    else r_rgb <= 8'h00;
  end

endmodule

// File: tb/tb_display_planes.sv
// Scoreboard bench for display_planes: directed lines, palette,
// line stepping, border/playfield window and underrun.
module tb_display_planes;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        res_n = 1'b0;
  logic        hires = 1'b0;
  logic        wide = 1'b0;
  logic        enable_pixel = 1'b0;
  logic [10:0] h_pixel = '0;
  logic [10:0] v_pixel = '0;
  logic        hsync = 1'b0;
  logic        vsync = 1'b0;
  logic        pal_we = 1'b0;
  logic [1:0]  pal_idx = '0;
  logic [7:0]  pal_data = '0;
  logic [9:0]  fb_addr;
  logic [15:0] fb_data;
  logic [7:0]  rgb;
  logic        outside;
  logic        und;

  logic [9:0]  fb_addr2;
  logic [1:0]  fb_data2 = 2'b10;
  logic [7:0]  rgb2;
  logic        outside2;
  logic        und2;

  logic [15:0] mem [1024];
  always @(posedge clk) fb_data <= mem[fb_addr];

  display_planes u_dut (
    .clk(clk), .res_n(res_n), .hires(hires), .wide(wide),
    .enable_pixel(enable_pixel), .h_pixel(h_pixel),
    .v_pixel(v_pixel), .hsync(hsync), .vsync(vsync),
    .pal_we(pal_we), .pal_idx(pal_idx), .pal_data(pal_data),
    .fb_addr(fb_addr), .fb_data(fb_data), .rgb(rgb),
    .outside_playfield(outside), .underrun(und)
  );

  display_planes #(
    .PLANES(2), .WORD_W(2), .H_MULT_HI(1)
  ) u_fast (
    .clk(clk), .res_n(res_n), .hires(hires), .wide(wide),
    .enable_pixel(enable_pixel), .h_pixel(h_pixel),
    .v_pixel(v_pixel), .hsync(hsync), .vsync(vsync),
    .pal_we(pal_we), .pal_idx(pal_idx), .pal_data(pal_data),
    .fb_addr(fb_addr2), .fb_data(fb_data2), .rgb(rgb2),
    .outside_playfield(outside2), .underrun(und2)
  );

  int checks = 0;
  int errors = 0;
  int npix = 0;
  logic [7:0] exq[$];
  logic track = 1'b0;
  logic en_d = 1'b0;

  task automatic chk(string nm, logic [15:0] act,
                     logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) en_d <= enable_pixel && track;

  // Monitor: every tracked pixel strobe yields one rgb to compare.
  always @(negedge clk) begin
    if (en_d) begin
      if (exq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_empty pix%0d got %h want none",
                 npix, rgb);
      end else begin
        chk($sformatf("pix%0d", npix), 16'(rgb),
            16'(exq.pop_front()));
      end
      npix++;
    end
  end

  function automatic logic [7:0] lores_exp(int i);
    int w;
    int o;
    w = i / 160;
    o = i % 160;
    case (w)
      0: return (o < 10) ? 8'h6D : 8'h00;
      1: return (o < 10) ? 8'hFF : 8'h00;
      2: return (o < 10) ? 8'hD9 : 8'h00;
      default: return (i <= 560) ? 8'hFF : 8'hE0;
    endcase
  endfunction

  task automatic do_reset();
    res_n = 1'b0;
    tick();
    tick();
    res_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    logic [9:0] a0;
    for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
    mem[0]   = 16'h8000;
    mem[512] = 16'h8000;
    mem[1]   = 16'h8000;
    mem[2]   = 16'h0000;
    mem[514] = 16'h8000;
    mem[3]   = 16'hFFFF;

    // Reset while pixels are being driven.
    enable_pixel = 1'b1;
    v_pixel = 11'd100;
    tick();
    tick();
    tick();
    chk("rst_rgb", 16'(rgb), 16'h00);
    chk("rst_fb_addr", 16'(fb_addr), 16'h000);
    chk("rst_underrun", 16'(und), 16'h0);
    chk("rst_underrun2", 16'(und2), 16'h0);
    enable_pixel = 1'b0;
    res_n = 1'b1;
    tick();

    // Lores line 80: four words, palette write mid-word 3.
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    v_pixel = 11'd80;
    hsync = 1'b1;
    tick();
    hsync = 1'b0;
    tick();
    chk("lo_addr_p0", 16'(fb_addr), 16'd0);
    tick();
    chk("lo_addr_p1", 16'(fb_addr), 16'd512);
    for (int i = 0; i < 6; i++) tick();
    h_pixel = 11'h7FC;
    tick();
    track = 1'b1;
    pal_idx = 2'd1;
    pal_data = 8'hE0;
    for (int i = 0; i < 640; i++) begin
      enable_pixel = 1'b1;
      h_pixel = 11'(i);
      pal_we = (i == 560);
      exq.push_back(lores_exp(i));
      tick();
    end
    enable_pixel = 1'b0;
    pal_we = 1'b0;
    track = 1'b0;
    tick();
    tick();
    chk("lo_sb_drained", 16'(exq.size()), 16'd0);
    chk("lo_no_underrun", 16'(und), 16'h0);

    // Hires: line base steps by 8 after five repeats.
    do_reset();
    hires = 1'b1;
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    for (int n = 0; n < 6; n++) begin
      a0 = (n < 5) ? 10'd0 : 10'd8;
      v_pixel = 11'(80 + n);
      hsync = 1'b1;
      tick();
      hsync = 1'b0;
      tick();
      chk($sformatf("hi_l%0d_p0", n), 16'(fb_addr), 16'(a0));
      tick();
      chk($sformatf("hi_l%0d_p1", n), 16'(fb_addr),
          16'(a0 + 10'd512));
      for (int i = 0; i < 5; i++) tick();
    end

    // Border lines and outside-playfield pixels.
    hires = 1'b0;
    track = 1'b1;
    enable_pixel = 1'b1;
    v_pixel = 11'd0;
    exq.push_back(8'hFF);
    tick();
    v_pixel = 11'd479;
    exq.push_back(8'hFF);
    tick();
    v_pixel = 11'd20;
    exq.push_back(8'h00);
    tick();
    enable_pixel = 1'b0;
    track = 1'b0;
    tick();
    tick();
    chk("bd_sb_drained", 16'(exq.size()), 16'd0);

    // Playfield window edges in both modes.
    wide = 1'b1;
    v_pixel = 11'd48;  #1 chk("wd_48", 16'(outside), 16'h0);
    v_pixel = 11'd47;  #1 chk("wd_47", 16'(outside), 16'h1);
    v_pixel = 11'd431; #1 chk("wd_431", 16'(outside), 16'h0);
    v_pixel = 11'd432; #1 chk("wd_432", 16'(outside), 16'h1);
    wide = 1'b0;
    v_pixel = 11'd48;  #1 chk("nr_48", 16'(outside), 16'h1);
    v_pixel = 11'd79;  #1 chk("nr_79", 16'(outside), 16'h1);
    v_pixel = 11'd80;  #1 chk("nr_80", 16'(outside), 16'h0);
    v_pixel = 11'd399; #1 chk("nr_399", 16'(outside), 16'h0);
    v_pixel = 11'd400; #1 chk("nr_400", 16'(outside), 16'h1);

    // Underrun on the fast-word instance, sticky until reset.
    do_reset();
    hires = 1'b1;
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    v_pixel = 11'd80;
    hsync = 1'b1;
    tick();
    hsync = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    h_pixel = 11'h7FC;
    tick();
    chk("ur_before", 16'(und2), 16'h0);
    enable_pixel = 1'b1;
    for (int i = 0; i < 6; i++) begin
      h_pixel = 11'(i);
      tick();
    end
    enable_pixel = 1'b0;
    chk("ur_set", 16'(und2), 16'h1);
    chk("ur_main_clear", 16'(und), 16'h0);
    for (int i = 0; i < 5; i++) tick();
    chk("ur_sticky", 16'(und2), 16'h1);
    res_n = 1'b0;
    tick();
    chk("ur_reset", 16'(und2), 16'h0);
    res_n = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
